adc_window_acc: RTL and testbench

- Parametrised successor to the single-channel ADC permit path: generic N_CH-channel block averaging plus window supervision.
- Consumes the time-multiplexed sample stream from the SPI ADC scanner (one channel per strobe).
- Per channel: averages 2^AVG_LOG2 samples, checks the average against a low/high window, and debounces the result.
- Feeds a registered global permit and a sticky alarm to the motion/generator control logic.

---
 rtl/adc_acc_pkg.sv | 19 +
 rtl/adc_win_debounce.sv | 50 +++++
 rtl/adc_window_acc.sv | 163 ++++++++++++++++
 tb/tb_adc_window_acc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_acc_pkg.sv
// rtl/adc_acc_pkg.sv - shared defaults, window state type and width helper for adc_window_acc
package adc_acc_pkg;

   localparam int DEF_N_CH      = 8;
   localparam int DEF_ADC_WIDTH = 10;
   localparam int DEF_AVG_LOG2  = 2;
   localparam int DEF_HOLD_CNT  = 4;

   typedef enum logic {
      WIN_OUT = 1'b0,
      WIN_IN  = 1'b1
   } win_state_t;

   // Index width that never collapses to zero bits for a single channel.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adc_win_debounce.sv
// rtl/adc_win_debounce.sv - per-channel window compare with consecutive-average debounce
module adc_win_debounce
   import adc_acc_pkg::*;
#(
   parameter int ADC_WIDTH = DEF_ADC_WIDTH,
   parameter int HOLD_CNT  = DEF_HOLD_CNT
) (
   input  logic                 i_clk,
   input  logic                 i_aclr_n,
   input  logic                 i_sclr,
   input  logic                 i_avg_valid,
   input  logic [ADC_WIDTH-1:0] i_avg,
   input  logic                 i_avg_err,
   input  logic [ADC_WIDTH-1:0] i_low,
   input  logic [ADC_WIDTH-1:0] i_high,
   output logic                 o_in_win
);

   localparam int              DW      = $clog2(HOLD_CNT + 1);
   localparam logic [DW-1:0]   HOLD_M1 = DW'(HOLD_CNT - 1);

   win_state_t    r_state;
   logic [DW-1:0] r_dbc;
   win_state_t    w_raw_state;

   // An inverted window (low > high) can never satisfy both bounds.
   assign w_raw_state = (!i_avg_err && (i_avg >= i_low) && (i_avg <= i_high)) ? WIN_IN : WIN_OUT;

   always_ff @(posedge i_clk or negedge i_aclr_n) begin
      if (!i_aclr_n) begin
         r_state <= WIN_OUT;
         r_dbc   <= '0;
      end else if (i_sclr) begin
         r_state <= WIN_OUT;
         r_dbc   <= '0;
      end else if (i_avg_valid) begin
         if (w_raw_state == r_state) begin
            r_dbc <= '0;
         end else if (r_dbc == HOLD_M1) begin
            r_state <= w_raw_state;
            r_dbc   <= '0;
         end else begin
            r_dbc <= r_dbc + 1'b1;
         end
      end
   end

   assign o_in_win = (r_state == WIN_IN);

endmodule

// File: rtl/adc_window_acc.sv
// rtl/adc_window_acc.sv - N_CH-channel block averager, window debounce, global permit and sticky alarm
// Define ADC_ACC_ROUND_EN for round-half-up saturated averages instead of truncation.
module adc_window_acc
   import adc_acc_pkg::*;
#(
   parameter int N_CH      = DEF_N_CH,
   parameter int ADC_WIDTH = DEF_ADC_WIDTH,
   parameter int AVG_LOG2  = DEF_AVG_LOG2,
   parameter int HOLD_CNT  = DEF_HOLD_CNT
) (
   input  logic                          clk,
   input  logic                          aclr_n,
   input  logic                          sclr,
   input  logic                          in_valid,
   input  logic [clog2_min1(N_CH)-1:0]   in_ch,
   input  logic [ADC_WIDTH-1:0]          in_data,
   input  logic                          in_err,
   input  logic [N_CH*ADC_WIDTH-1:0]     low,
   input  logic [N_CH*ADC_WIDTH-1:0]     high,
   input  logic [N_CH-1:0]               ch_ena,
   input  logic                          soft_permit,
   input  logic                          alarm_clr,
   output logic [N_CH*ADC_WIDTH-1:0]     avg,
   output logic [N_CH-1:0]               avg_valid,
   output logic [N_CH-1:0]               avg_err,
   output logic [N_CH-1:0]               in_win,
   output logic                          permit,
   output logic                          alarm
);

   localparam int AW = ADC_WIDTH + AVG_LOG2;
   localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   logic [AW-1:0]        r_acc [N_CH];
   logic [CW-1:0]        r_cnt [N_CH];
   logic [ADC_WIDTH-1:0] r_avg [N_CH];
   logic [N_CH-1:0]      r_errf;
   logic [N_CH-1:0]      r_avg_valid;
   logic [N_CH-1:0]      r_avg_err;
   logic                 r_permit;
   logic                 r_fall;
   logic                 r_alarm;

   logic                 w_ch_ok;
   logic                 w_last;
   logic                 w_err_any;
   logic [AW-1:0]        w_sum;
   logic [ADC_WIDTH-1:0] w_avg;
   logic [N_CH-1:0]      w_in_win;
   logic                 w_permit_nxt;

   assign w_ch_ok   = in_valid && (32'(in_ch) < 32'(N_CH));
   assign w_sum     = r_acc[in_ch] + AW'(in_data);
   assign w_err_any = r_errf[in_ch] | in_err;

   generate
      if (AVG_LOG2 == 0) begin : g_pass
         assign w_last = 1'b1;
      end else begin : g_blk
         assign w_last = &r_cnt[in_ch];
      end
   endgenerate

`ifdef ADC_ACC_ROUND_EN
   localparam logic [AW:0] RND = (AW+1)'((1 << AVG_LOG2) >> 1);
   logic [AW:0] w_rsum;
   logic [AW:0] w_rq;

   assign w_rsum = {1'b0, w_sum} + RND;
   assign w_rq   = w_rsum >> AVG_LOG2;
   assign w_avg  = (|w_rq[AW:ADC_WIDTH]) ? '1 : w_rq[ADC_WIDTH-1:0];
`else
   assign w_avg  = ADC_WIDTH'(w_sum >> AVG_LOG2);
`endif

   // Stage 1: the final sample of a block is folded in combinationally, so no extra cycle.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         for (int i = 0; i < N_CH; i++) begin
            r_acc[i] <= '0;
            r_cnt[i] <= '0;
            r_avg[i] <= '0;
         end
         r_errf      <= '0;
         r_avg_valid <= '0;
         r_avg_err   <= '0;
      end else if (sclr) begin
         for (int i = 0; i < N_CH; i++) begin
            r_acc[i] <= '0;
            r_cnt[i] <= '0;
            r_avg[i] <= '0;
         end
         r_errf      <= '0;
         r_avg_valid <= '0;
         r_avg_err   <= '0;
      end else begin
         r_avg_valid <= '0;
         if (w_ch_ok) begin
            if (w_last) begin
               r_acc[in_ch]       <= '0;
               r_cnt[in_ch]       <= '0;
               r_errf[in_ch]      <= 1'b0;
               r_avg_valid[in_ch] <= 1'b1;
               r_avg_err[in_ch]   <= w_err_any;
               if (!w_err_any) begin
                  r_avg[in_ch] <= w_avg;
               end
            end else begin
               r_acc[in_ch]  <= w_sum;
               r_cnt[in_ch]  <= r_cnt[in_ch] + 1'b1;
               r_errf[in_ch] <= w_err_any;
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < N_CH; g++) begin : g_ch
         assign avg[g*ADC_WIDTH +: ADC_WIDTH] = r_avg[g];

         adc_win_debounce #(
            .ADC_WIDTH (ADC_WIDTH),
            .HOLD_CNT  (HOLD_CNT)
         ) u_dbc (
            .i_clk       (clk),
            .i_aclr_n    (aclr_n),
            .i_sclr      (sclr),
            .i_avg_valid (r_avg_valid[g]),
            .i_avg       (r_avg[g]),
            .i_avg_err   (r_avg_err[g]),
            .i_low       (low[g*ADC_WIDTH +: ADC_WIDTH]),
            .i_high      (high[g*ADC_WIDTH +: ADC_WIDTH]),
            .o_in_win    (w_in_win[g])
         );
      end
   endgenerate

   assign w_permit_nxt = soft_permit & (&(w_in_win | ~ch_ena));

   // r_fall remembers a supervised drop so the alarm lands one cycle after permit falls.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_permit <= 1'b0;
         r_fall   <= 1'b0;
         r_alarm  <= 1'b0;
      end else if (sclr) begin
         r_permit <= 1'b0;
         r_fall   <= 1'b0;
         r_alarm  <= 1'b0;
      end else begin
         r_permit <= w_permit_nxt;
         r_fall   <= r_permit & ~w_permit_nxt & soft_permit;
         r_alarm  <= r_fall | (r_alarm & ~alarm_clr);
      end
   end

   assign avg_valid = r_avg_valid;
   assign avg_err   = r_avg_err;
   assign in_win    = w_in_win;
   assign permit    = r_permit;
   assign alarm     = r_alarm;

endmodule

// File: tb/tb_adc_window_acc.sv
// tb/tb_adc_window_acc.sv - directed bench for adc_window_acc with a queue-based block/window model
module tb_adc_window_acc;

   localparam int N_CH = 8;
   localparam int N6   = 6;
   localparam int W    = 10;
   localparam int L    = 2;
   localparam int HOLD = 4;
   localparam int NS   = 1 << L;
   localparam int MAXV = (1 << W) - 1;
`ifdef ADC_ACC_ROUND_EN
   localparam int EXP_CH3 = 102;
`else
   localparam int EXP_CH3 = 101;
`endif

   logic              clk = 1'b0;
   logic              aclr_n = 1'b0, sclr = 1'b0, in_valid = 1'b0, in_err = 1'b0;
   logic              soft_permit = 1'b0, alarm_clr = 1'b0;
   logic [2:0]        in_ch = '0;
   logic [W-1:0]      in_data = '0;
   logic [N_CH*W-1:0] low = '0, high = '0;
   logic [N_CH-1:0]   ch_ena = '0;

   logic [N_CH*W-1:0] avg8;
   logic [N_CH-1:0]   avg_valid8, avg_err8, in_win8;
   logic              permit8, alarm8;
   logic [N6*W-1:0]   avg6;
   logic [N6-1:0]     avg_valid6, avg_err6, in_win6;
   logic              permit6, alarm6;

   always #5 clk = ~clk;

   adc_window_acc #(.N_CH(N_CH), .ADC_WIDTH(W), .AVG_LOG2(L), .HOLD_CNT(HOLD)) u_dut (
      .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .in_valid(in_valid), .in_ch(in_ch),
      .in_data(in_data), .in_err(in_err), .low(low), .high(high), .ch_ena(ch_ena),
      .soft_permit(soft_permit), .alarm_clr(alarm_clr), .avg(avg8), .avg_valid(avg_valid8),
      .avg_err(avg_err8), .in_win(in_win8), .permit(permit8), .alarm(alarm8));

   // Six-channel copy shares the 3-bit channel index, so indices 6 and 7 are out of range for it.
   adc_window_acc #(.N_CH(N6), .ADC_WIDTH(W), .AVG_LOG2(L), .HOLD_CNT(HOLD)) u_dut6 (
      .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .in_valid(in_valid), .in_ch(in_ch),
      .in_data(in_data), .in_err(in_err), .low(low[N6*W-1:0]), .high(high[N6*W-1:0]),
      .ch_ena(ch_ena[N6-1:0]), .soft_permit(soft_permit), .alarm_clr(alarm_clr), .avg(avg6),
      .avg_valid(avg_valid6), .avg_err(avg_err6), .in_win(in_win6), .permit(permit6), .alarm(alarm6));

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s ch%0d at %0t: got %0d, expected %0d", name, ch, $time, act, exp);
      end
   endtask

   // Model: each channel keeps the raw samples of its open block and a run length of disagreeing averages.
   int unsigned  m_blk [N_CH][$];
   bit           m_blkerr [N_CH];
   logic [W-1:0] m_avg [N_CH];
   bit           m_aval [N_CH], m_aerr [N_CH], m_win [N_CH];
   int           m_dis [N_CH];
   bit           m_permit, m_fall, m_alarm;

   task automatic m_clear();
      for (int i = 0; i < N_CH; i++) begin
         m_blk[i].delete();
         m_blkerr[i] = 0; m_avg[i] = '0; m_aval[i] = 0; m_aerr[i] = 0; m_win[i] = 0; m_dis[i] = 0;
      end
      m_permit = 0; m_fall = 0; m_alarm = 0;
   endtask

   always @(posedge clk or negedge aclr_n) begin
      if (!aclr_n || sclr) begin
         m_clear();
      end else begin
         bit p_new;
         int c;
         longint sum;
         p_new = soft_permit;
         for (int i = 0; i < N_CH; i++)
            if (ch_ena[i] && !m_win[i]) p_new = 0;
         m_alarm  = m_fall || (m_alarm && !alarm_clr);
         m_fall   = m_permit && !p_new && soft_permit;
         m_permit = p_new;
         for (int i = 0; i < N_CH; i++) begin
            if (m_aval[i]) begin
               bit raw;
               raw = !m_aerr[i] && (low[i*W +: W] <= m_avg[i]) && (m_avg[i] <= high[i*W +: W]);
               if (raw == m_win[i]) m_dis[i] = 0;
               else begin
                  m_dis[i]++;
                  if (m_dis[i] == HOLD) begin m_win[i] = raw; m_dis[i] = 0; end
               end
            end
            m_aval[i] = 0;
         end
         if (in_valid && in_ch < N_CH) begin
            c = int'(in_ch);
            m_blk[c].push_back(in_data);
            m_blkerr[c] |= in_err;
            if (m_blk[c].size() == NS) begin
               m_aval[c] = 1;
               m_aerr[c] = m_blkerr[c];
               if (!m_blkerr[c]) begin
                  sum = 0;
                  foreach (m_blk[c][k]) sum += m_blk[c][k];
`ifdef ADC_ACC_ROUND_EN
                  sum += NS / 2;
`endif
                  sum = sum / NS;
                  m_avg[c] = W'((sum > MAXV) ? MAXV : sum);
               end
               m_blk[c].delete();
               m_blkerr[c] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < N_CH; i++) begin
            check("avg", i, 32'(avg8[i*W +: W]), 32'(m_avg[i]));
            check("avg_valid", i, 32'(avg_valid8[i]), 32'(m_aval[i]));
            check("avg_err", i, 32'(avg_err8[i]), 32'(m_aerr[i]));
            check("in_win", i, 32'(in_win8[i]), 32'(m_win[i]));
            if (i < N6) begin
               check("avg6", i, 32'(avg6[i*W +: W]), 32'(m_avg[i]));
               check("avg_valid6", i, 32'(avg_valid6[i]), 32'(m_aval[i]));
               check("avg_err6", i, 32'(avg_err6[i]), 32'(m_aerr[i]));
               check("in_win6", i, 32'(in_win6[i]), 32'(m_win[i]));
            end
         end
         check("permit", -1, 32'(permit8), 32'(m_permit));
         check("alarm", -1, 32'(alarm8), 32'(m_alarm));
         check("permit6", -1, 32'(permit6), 32'(m_permit));
         check("alarm6", -1, 32'(alarm6), 32'(m_alarm));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic sample(input int ch, input int d, input bit e = 1'b0);
      in_valid = 1'b1; in_ch = 3'(ch); in_data = W'(d); in_err = e;
      tick();
      in_valid = 1'b0; in_err = 1'b0;
   endtask

   task automatic block(input int ch, input int d, input int nblk = 1);
      repeat (nblk * NS) sample(ch, d);
   endtask

   task automatic set_win(input int ch, input int lo, input int hi);
      low[ch*W +: W] = W'(lo); high[ch*W +: W] = W'(hi);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N_CH; i++) set_win(i, 200, 800);
      tick(2);
      aclr_n = 1'b1;
      chk_en = 1'b1;
      check("rst_avg", -1, 32'(avg8 != '0), 0);
      check("rst_permit", -1, 32'(permit8), 0);
      check("rst_alarm", -1, 32'(alarm8), 0);

      // Block average on ch3; strobe lasts one cycle.
      for (int k = 0; k < 4; k++) begin
         sample(3, 100 + k);
         if (k == 2) check("lit_valid_early", 3, 32'(avg_valid8[3]), 0);
      end
      check("lit_valid", 3, 32'(avg_valid8[3]), 1);
      check("lit_avg", 3, 32'(avg8[3*W +: W]), EXP_CH3);
      tick();
      check("lit_valid_drop", 3, 32'(avg_valid8[3]), 0);

      // Error masking on ch0, then a clean block and enough agreeing blocks to enter window.
      sample(0, 500); sample(0, 500, 1'b1); sample(0, 500); sample(0, 500);
      check("lit_err_avg", 0, 32'(avg8[0 +: W]), 0);
      check("lit_err_flag", 0, 32'(avg_err8[0]), 1);
      block(0, 500);
      check("lit_clean_avg", 0, 32'(avg8[0 +: W]), 500);
      check("lit_clean_err", 0, 32'(avg_err8[0]), 0);
      block(0, 500, 3);

      // Debounce on ch1.
      block(1, 500, 3); tick();
      check("lit_dbc3", 1, 32'(in_win8[1]), 0);
      block(1, 500); tick();
      check("lit_dbc4", 1, 32'(in_win8[1]), 1);
      block(1, 900, 2); block(1, 500); block(1, 900, 3); tick();
      check("lit_dbc_hold", 1, 32'(in_win8[1]), 1);
      block(1, 900); tick();
      check("lit_dbc_out", 1, 32'(in_win8[1]), 0);

      // Permit and alarm.
      block(1, 500, 4); tick();
      ch_ena = 8'h03; soft_permit = 1'b1; tick(2);
      check("lit_permit_up", -1, 32'(permit8), 1);
      block(1, 900, 4); tick();
      check("lit_win_fall", 1, 32'(in_win8[1]), 0);
      tick();
      check("lit_permit_fall", -1, 32'(permit8), 0);
      check("lit_alarm_wait", -1, 32'(alarm8), 0);
      tick();
      check("lit_alarm_set", -1, 32'(alarm8), 1);
      ch_ena = 8'h01; tick();
      check("lit_permit_ch0", -1, 32'(permit8), 1);
      ch_ena = 8'h07; tick();
      alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
      check("lit_set_wins", -1, 32'(alarm8), 1);
      alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
      check("lit_alarm_clr", -1, 32'(alarm8), 0);
      ch_ena = 8'h01; tick();
      soft_permit = 1'b0; tick(2);
      check("lit_soft_fall", -1, 32'(alarm8), 0);
      ch_ena = 8'h00; soft_permit = 1'b1; tick();
      check("lit_no_ena", -1, 32'(permit8), 1);

      // Boundaries: full-scale block, out-of-range index on the six-channel copy, degenerate windows.
      block(7, MAXV);
      check("lit_max", 7, 32'(avg8[7*W +: W]), MAXV);
      check("lit_oob", -1, 32'(avg_valid6), 0);
      sample(6, 50); sample(6, 60);
      set_win(4, 300, 300); block(4, 300, 4); tick();
      check("lit_eq_win", 4, 32'(in_win8[4]), 1);
      set_win(5, 400, 300); block(5, 350, 4); tick();
      check("lit_inv_win", 5, 32'(in_win8[5]), 0);

      // Asynchronous reset in the middle of a block.
      sample(2, 1000); sample(2, 1000);
      aclr_n = 1'b0; #3;
      check("lit_aclr_avg", -1, 32'(avg8 != '0), 0);
      check("lit_aclr_win", -1, 32'(in_win8), 0);
      tick(); aclr_n = 1'b1;
      block(2, 40);
      check("lit_aclr_fresh", 2, 32'(avg8[2*W +: W]), 40);

      // Synchronous clear in the middle of a block.
      sample(2, 1000); sample(2, 1000);
      sclr = 1'b1; tick(); sclr = 1'b0;
      check("lit_sclr_avg", -1, 32'(avg8 != '0), 0);
      check("lit_sclr_permit", -1, 32'(permit8), 0);
      block(2, 60);
      check("lit_sclr_fresh", 2, 32'(avg8[2*W +: W]), 60);

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
